pal_sync_gen: RTL and testbench

- Generates the PAL-style horizontal and field sync strobes HSn and FSn, plus blanking and position outputs, from the single system clock.
- It is the transmitting end of the HSn/FSn line-count interface. Downstream line counters count HSn falling edges while FSn is high, and clear while FSn is low.
- Sits between the master clock divider (CE) and the VDG / display datapath and line-counter logic.

---
 rtl/pal_sync_gen.sv | 92 +++++++++
 tb/tb_pal_sync_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pal_sync_gen.sv
// PAL-style sync generator: produces the HSn/FSn strobes, the blanking windows
// and the raster position from one clock qualified by CE.
module pal_sync_gen #(
  parameter int unsigned H_TOTAL     = 448,
  parameter int unsigned HS_WIDTH    = 32,
  parameter int unsigned H_ACT_START = 96,
  parameter int unsigned H_ACT_LEN   = 256,
  parameter int unsigned V_TOTAL     = 312,
  parameter int unsigned FS_START    = 0,
  parameter int unsigned FS_LINES    = 8,
  parameter int unsigned FS_HOFF     = 224,
  parameter int unsigned V_ACT_START = 40,
  parameter int unsigned V_ACT_LEN   = 192
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       CE,
  input  logic       Restart,
  output logic       HSn,
  output logic       FSn,
  output logic       HBLANKn,
  output logic       VBLANKn,
  output logic [9:0] Col,
  output logic [8:0] Row,
  output logic       FrameTick
);

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  HS_W    = 10'(HS_WIDTH);
  localparam logic [10:0] HA_S    = 11'(H_ACT_START);
  localparam logic [10:0] HA_E    = 11'(H_ACT_START + H_ACT_LEN);
  localparam logic [9:0]  FS_H    = 10'(FS_HOFF);
  localparam logic [8:0]  V_LAST  = 9'(V_TOTAL - 1);
  localparam logic [8:0]  FS_V0   = 9'(FS_START);
  localparam logic [8:0]  FS_V1   = 9'(FS_START + FS_LINES);
  localparam logic [9:0]  VA_S    = 10'(V_ACT_START);
  localparam logic [9:0]  VA_E    = 10'(V_ACT_START + V_ACT_LEN);

  logic [9:0] hcnt, hnext;
  logic [8:0] vcnt, vnext;
  logic       fs_win;
  logic [10:0] hx;
  logic [9:0]  vx;

  // Next raster position, and whether that position lies inside the field-sync window.
  // FSn is decoded from position rather than toggled on edges, so a Restart landing
  // anywhere yields the correct level without extra state.
  always_comb begin
    hnext = hcnt;
    vnext = vcnt;
    if (Restart) begin
      hnext = '0;
      vnext = '0;
    end else if (hcnt == H_LAST) begin
      hnext = '0;
      vnext = (vcnt == V_LAST) ? '0 : vcnt + 9'd1;
    end else begin
      hnext = hcnt + 10'd1;
    end
    hx = {1'b0, hnext};
    vx = {1'b0, vnext};
    fs_win = ((vnext > FS_V0) || ((vnext == FS_V0) && (hnext >= FS_H))) &&
             ((vnext < FS_V1) || ((vnext == FS_V1) && (hnext < FS_H)));
  end

  // Counters and outputs, all registered from the next-position decode.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hcnt      <= H_LAST;
      vcnt      <= V_LAST;
      HSn       <= 1'b1;
      FSn       <= 1'b1;
      HBLANKn   <= 1'b0;
      VBLANKn   <= 1'b0;
      FrameTick <= 1'b0;
    end else if (CE) begin
      hcnt      <= hnext;
      vcnt      <= vnext;
      HSn       <= !(hnext < HS_W);
      FSn       <= !fs_win;
      HBLANKn   <= (hx >= HA_S) && (hx < HA_E);
      VBLANKn   <= (vx >= VA_S) && (vx < VA_E);
      FrameTick <= (hnext == '0) && (vnext == '0);
    end else begin
      FrameTick <= 1'b0;
    end
  end

  assign Col = hcnt;
  assign Row = vcnt;

endmodule

// File: tb/tb_pal_sync_gen.sv
// Directed bench for pal_sync_gen: reset, line/field timing, receiver model,
// blanking, Restart behaviour, CE at 1-in-3 and asynchronous reset.
module tb_pal_sync_gen;

  logic       CLK = 1'b0;
  logic       RSTn, CE, Restart;
  logic       HSn, FSn, HBLANKn, VBLANKn, FrameTick;
  logic [9:0] Col;
  logic [8:0] Row;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  pal_sync_gen #(
    .H_TOTAL(448), .HS_WIDTH(32), .H_ACT_START(96), .H_ACT_LEN(256),
    .V_TOTAL(312), .FS_START(0), .FS_LINES(8), .FS_HOFF(224),
    .V_ACT_START(40), .V_ACT_LEN(192)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .CE(CE), .Restart(Restart),
    .HSn(HSn), .FSn(FSn), .HBLANKn(HBLANKn), .VBLANKn(VBLANKn),
    .Col(Col), .Row(Row), .FrameTick(FrameTick)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int c, r, rx, rx_r8, rx_r9, both_row;
  int pos_err, hs_err, hb_err, vb_err, fs_err, fs_col0, ft_cnt, fall_k, rise_k;
  int low_cnt, ft_hi, nfall, fs_fall_n;
  int fall_n [3];
  logic prev_hs, prev_fs, exp_fs;

  initial begin
    RSTn = 1'b0; CE = 1'b0; Restart = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_col", Col, 447);
    check("rst_row", Row, 311);
    check("rst_hsn", HSn, 1);
    check("rst_fsn", FSn, 1);
    check("rst_hblank", HBLANKn, 0);
    check("rst_vblank", VBLANKn, 0);
    check("rst_tick", FrameTick, 0);

    // First CE edge enters (0,0)
    RSTn = 1'b1; CE = 1'b1;
    step();
    check("first_col", Col, 0);
    check("first_row", Row, 0);
    check("first_hsn", HSn, 0);
    check("first_tick", FrameTick, 1);
    check("first_fsn", FSn, 1);
    check("first_hblank", HBLANKn, 0);
    check("first_vblank", VBLANKn, 0);

    prev_hs = HSn; prev_fs = FSn; rx = 0; rx_r8 = -1; rx_r9 = -1; both_row = -1;
    pos_err = 0; hs_err = 0; hb_err = 0; vb_err = 0; fs_err = 0;
    fs_col0 = 0; ft_cnt = 0; fall_k = -1; rise_k = -1;
    for (int k = 1; k < 41 * 448; k++) begin
      step();
      c = k % 448;
      r = k / 448;
      if (Col !== 10'(c) || Row !== 9'(r)) pos_err++;
      if (HSn !== (c >= 32)) hs_err++;
      if (HBLANKn !== (c >= 96 && c < 352)) hb_err++;
      if (VBLANKn !== (r >= 40 && r < 232)) vb_err++;
      exp_fs = !(k >= 224 && k < 8 * 448 + 224);
      if (FSn !== exp_fs) fs_err++;
      if (FSn !== prev_fs) begin
        if (c == 0) fs_col0++;
        if (!FSn) fall_k = k; else rise_k = k;
      end
      if (FrameTick) ft_cnt++;
      if (!FSn) rx = 0;
      else if (prev_hs && !HSn) rx++;
      if (k == 8 * 448 + 447) rx_r8 = rx;
      if (k == 9 * 448 + 447) rx_r9 = rx;
      if (both_row < 0 && rx[3] && rx[4]) both_row = r;
      prev_hs = HSn;
      prev_fs = FSn;
    end
    check("pos_errors", pos_err, 0);
    check("hsn_errors", hs_err, 0);
    check("hblank_errors", hb_err, 0);
    check("vblank_errors", vb_err, 0);
    check("fsn_errors", fs_err, 0);
    check("fsn_fall_clk", fall_k, 224);
    check("fsn_rise_clk", rise_k, 3808);
    check("fsn_low_len", rise_k - fall_k, 3584);
    check("fsn_edge_col0", fs_col0, 0);
    check("tick_midframe", ft_cnt, 0);
    check("rx_row8", rx_r8, 0);
    check("rx_row9", rx_r9, 1);
    check("rx_bits34_row", both_row, 32);

    // Restart from (40,447)
    Restart = 1'b1; step(); Restart = 1'b0;
    check("rs_col", Col, 0);
    check("rs_row", Row, 0);
    check("rs_tick", FrameTick, 1);
    check("rs_fsn", FSn, 1);

    // Restart at (5,300) while inside the field-sync window
    repeat (5 * 448 + 300) step();
    check("pre_rs_col", Col, 300);
    check("pre_rs_row", Row, 5);
    check("pre_rs_fsn", FSn, 0);
    Restart = 1'b1; step(); Restart = 1'b0;
    check("rs5_col", Col, 0);
    check("rs5_row", Row, 0);
    check("rs5_tick", FrameTick, 1);
    check("rs5_fsn", FSn, 1);
    check("rs5_hsn", HSn, 0);

    // Restart at (0,0) re-enters (0,0)
    Restart = 1'b1; step(); Restart = 1'b0;
    check("rs00_col", Col, 0);
    check("rs00_tick", FrameTick, 1);
    step();
    check("after_rs00_col", Col, 1);
    check("after_rs00_tick", FrameTick, 0);

    // FrameTick clears with CE=0, state holds
    Restart = 1'b1; step(); Restart = 1'b0; CE = 1'b0;
    step();
    check("ce0_tick_clear", FrameTick, 0);
    check("ce0_hold_col", Col, 0);

    // Restart ignored with CE=0
    CE = 1'b1;
    repeat (40) step();
    CE = 1'b0; Restart = 1'b1;
    repeat (3) step();
    Restart = 1'b0;
    check("ce0_rs_col", Col, 40);
    check("ce0_rs_row", Row, 0);
    check("ce0_rs_tick", FrameTick, 0);
    check("ce0_rs_hsn", HSn, 1);

    // CE at 1-in-3, starting with a Restart
    prev_hs = HSn; prev_fs = FSn; low_cnt = 0; ft_hi = 0; nfall = 0; fs_fall_n = -1;
    for (int n = 0; n < 3 * 1344; n++) begin
      CE = (n % 3 == 0);
      Restart = (n == 0);
      step();
      if (!HSn && n < 1344) low_cnt++;
      if (FrameTick) ft_hi++;
      if (prev_hs && !HSn && nfall < 3) begin
        fall_n[nfall] = n;
        nfall++;
      end
      if (prev_fs && !FSn && fs_fall_n < 0) fs_fall_n = n;
      prev_hs = HSn;
      prev_fs = FSn;
    end
    Restart = 1'b0;
    check("ce3_hs_falls", nfall, 3);
    check("ce3_fall0", fall_n[0], 0);
    check("ce3_fall1", fall_n[1], 1344);
    check("ce3_fall2", fall_n[2], 2688);
    check("ce3_hs_low", low_cnt, 96);
    check("ce3_tick_width", ft_hi, 1);
    check("ce3_fsn_fall", fs_fall_n, 672);

    // Asynchronous reset mid-line
    CE = 1'b1;
    repeat (100) step();
    check("pre_arst_col", Col, 99);
    check("pre_arst_hblank", HBLANKn, 1);
    #2 RSTn = 1'b0;
    #1;
    check("arst_col", Col, 447);
    check("arst_row", Row, 311);
    check("arst_hsn", HSn, 1);
    check("arst_fsn", FSn, 1);
    check("arst_hblank", HBLANKn, 0);
    check("arst_tick", FrameTick, 0);
    RSTn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
